l2_conv_stream_gen: RTL
=======================

L2_CONV_STREAM_GEN -- requirements
Module: l2_conv_stream_gen

Interface
REQ-001 SHALL have parameter COLS, default 12, beats per line.
REQ-002 SHALL have parameter ROWS, default 25, lines per channel.
REQ-003 SHALL have parameter CHANS, default 8, channels per frame.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port Start_i  input  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port Abort_i  input  1  synchronous frame abort.
REQ-008 SHALL have port DataAvail_i  input  1  upstream line buffer holds a beat this cycle.
REQ-009 SHALL have port ConvValid_o  output  1  frame window: high for the whole frame, low otherwise.
REQ-010 SHALL have port vbit_o  output  1  beat strobe: one conv result emitted this cycle.
REQ-011 SHALL have port ColIdx_o  output  4  column of current beat.
REQ-012 SHALL have port RowIdx_o  output  5  row of current beat.
REQ-013 SHALL have port ChanIdx_o  output  3  channel of current beat.
REQ-014 SHALL have port Busy_o  output  1  high when state is not IDLE.
REQ-015 SHALL have port Done_o  output  1  single-cycle frame-complete pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, GAP, DONE, held in one state register.
REQ-017 SHALL move IDLE->RUN on the edge where Start_i=1; ConvValid_o=1 from the following cycle.
REQ-018 SHALL drive vbit_o = (state==RUN) & DataAvail_i, combinationally; no beat is emitted in other states.
REQ-019 SHALL advance counters only on vbit_o: Col 0..COLS-1, wrap to 0 and increment Row; Row 0..ROWS-1, wrap and increment Chan; Chan 0..CHANS-1.
REQ-020 SHALL hold all counters unchanged when in RUN with DataAvail_i=0; no timeout.
REQ-021 SHALL treat the beat at (Col=COLS-1, Row=ROWS-1, Chan=CHANS-1) as last: next state DONE, counters cleared to 0.
REQ-022 SHALL in DONE drive ConvValid_o=0, vbit_o=0, Done_o=1 for exactly one cycle, then enter IDLE.
REQ-023 SHALL ignore Start_i outside IDLE; Start_i high in the DONE cycle does not start a frame.
REQ-024 SHALL on Abort_i=1 (any state) enter IDLE next cycle with counters 0, ConvValid_o=0, no Done_o pulse; Abort_i wins over Start_i and over a simultaneous last beat.
REQ-025 SHALL emit COLS*ROWS*CHANS beats per frame (2400 at defaults), so a downstream 3-bit channel counter ends at 0.

Reset
REQ-026 SHALL on rstn=0 at a clock edge set state IDLE, all counters 0, ConvValid_o=0, Done_o=0, Busy_o=0; vbit_o is then 0.
REQ-027 SHALL treat rstn low mid-frame identically to REQ-026 with no Done_o pulse.

Configuration
REQ-028 SHALL with L2_ROW_GAP_EN defined enter GAP after every row-final beat except the frame-final beat, stay 2 cycles (ConvValid_o=1, vbit_o=0, counters held), then return to RUN.
REQ-029 SHALL with L2_ROW_GAP_EN undefined never enter GAP; RUN continues directly to the next row.

Structure
REQ-030 SHALL place COLS/ROWS/CHANS defaults, GAP length (2) and the FSM state encoding in shared package l2_conv_pkg.
REQ-031 SHALL implement the col/row/chan cascade in one sub-module l2_beat_counter (inputs clk, rstn, clr, inc; outputs indices and last flag).

Verification
REQ-032 SHALL check: rstn low, DataAvail_i=1, Start_i=1 -> ConvValid_o=0, vbit_o=0, Done_o=0.
REQ-033 SHALL check: Start_i pulse at cycle 0, DataAvail_i=1, no gap -> vbit_o high cycles 1..2400, Done_o at cycle 2401, indices (11,24,7) at cycle 2400.
REQ-034 SHALL check: L2_ROW_GAP_EN defined, same stimulus -> 199 gaps of 2 cycles, Done_o at cycle 2799.
REQ-035 SHALL check: DataAvail_i toggled randomly 50% -> exactly 2400 vbit_o beats, counters frozen on DataAvail_i=0.
REQ-036 SHALL check: Abort_i at beat 137 -> IDLE next cycle, counters 0, no Done_o; new Start_i restarts at (0,0,0).
REQ-037 SHALL check: Start_i held high through DONE -> new frame only from the IDLE cycle after DONE.

Source files
------------

// File: rtl/l2_conv_pkg.sv
// Shared definitions for the L2 convolution beat stream generator:
// frame geometry defaults, row-gap length and FSM state encoding.
package l2_conv_pkg;

    localparam int COLS_DEFAULT  = 12;
    localparam int ROWS_DEFAULT  = 25;
    localparam int CHANS_DEFAULT = 8;
    localparam int GAP_LEN       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } convState_t;

endpackage

// File: rtl/l2_beat_counter.sv
// Column/row/channel cascade for the conv stream; advances on inc,
// clears on clr or reset, and flags the frame-final beat position.
module l2_beat_counter
    import l2_conv_pkg::*;
#(
    parameter int COLS  = COLS_DEFAULT,
    parameter int ROWS  = ROWS_DEFAULT,
    parameter int CHANS = CHANS_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] colIdx,
    output logic [4:0] rowIdx,
    output logic [2:0] chanIdx,
    output logic       lastBeat
);

    localparam logic [3:0] COL_MAX  = 4'(COLS - 1);
    localparam logic [4:0] ROW_MAX  = 5'(ROWS - 1);
    localparam logic [2:0] CHAN_MAX = 3'(CHANS - 1);

    // The frame-final beat wraps every index to zero, so no extra clear is needed.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            colIdx  <= '0;
            rowIdx  <= '0;
            chanIdx <= '0;
        end else if (inc) begin
            if (colIdx == COL_MAX) begin
                colIdx <= '0;
                if (rowIdx == ROW_MAX) begin
                    rowIdx <= '0;
                    if (chanIdx == CHAN_MAX) begin
                        chanIdx <= '0;
                    end else begin
                        chanIdx <= chanIdx + 3'd1;
                    end
                end else begin
                    rowIdx <= rowIdx + 5'd1;
                end
            end else begin
                colIdx <= colIdx + 4'd1;
            end
        end
    end

    assign lastBeat = (colIdx == COL_MAX) && (rowIdx == ROW_MAX) && (chanIdx == CHAN_MAX);

endmodule

// File: rtl/l2_conv_stream_gen.sv
// Frame-level beat stream generator for the L2 conv engine.
// Optional build macro L2_ROW_GAP_EN inserts a fixed idle gap after each row.
module l2_conv_stream_gen
    import l2_conv_pkg::*;
#(
    parameter int COLS  = COLS_DEFAULT,
    parameter int ROWS  = ROWS_DEFAULT,
    parameter int CHANS = CHANS_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       Start_i,
    input  logic       Abort_i,
    input  logic       DataAvail_i,
    output logic       ConvValid_o,
    output logic       vbit_o,
    output logic [3:0] ColIdx_o,
    output logic [4:0] RowIdx_o,
    output logic [2:0] ChanIdx_o,
    output logic       Busy_o,
    output logic       Done_o
);

    convState_t state, nextState;
    logic       lastBeat;

`ifdef L2_ROW_GAP_EN
    logic [1:0] gapCnt;
    logic       rowEnd;

    assign rowEnd = (ColIdx_o == 4'(COLS - 1));

    always_ff @(posedge clk) begin
        if (!rstn || state != GAP) begin
            gapCnt <= '0;
        end else begin
            gapCnt <= gapCnt + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Abort overrides everything, including a start request or the last beat.
    always_comb begin
        nextState = state;
        if (Abort_i) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: if (Start_i) nextState = RUN;
                RUN: begin
                    if (vbit_o && lastBeat) begin
                        nextState = DONE;
`ifdef L2_ROW_GAP_EN
                    end else if (vbit_o && rowEnd) begin
                        nextState = GAP;
`endif
                    end
                end
`ifdef L2_ROW_GAP_EN
                GAP:  if (gapCnt == 2'(GAP_LEN - 1)) nextState = RUN;
`else
                GAP:  nextState = RUN;
`endif
                DONE: nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        vbit_o      = (state == RUN) && DataAvail_i;
        ConvValid_o = (state == RUN) || (state == GAP);
        Busy_o      = (state != IDLE);
        Done_o      = (state == DONE);
    end

    l2_beat_counter #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .CHANS (CHANS)
    ) u_beatCounter (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (Abort_i),
        .inc      (vbit_o),
        .colIdx   (ColIdx_o),
        .rowIdx   (RowIdx_o),
        .chanIdx  (ChanIdx_o),
        .lastBeat (lastBeat)
    );

endmodule
